pipeline_cache_ctrl: RTL and testbench

//  Control FSM for the 2-stage pipelined cache: drives load of the stage-1/stage-2 pipeline register,

---
 rtl/pipeline_cache_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_cache_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_cache_ctrl.sv
// pipeline_cache_ctrl: control FSM for the 2-stage pipelined cache.
// Hits stream one per cycle; misses stall, write back, fetch, fill, replay.
// Ports: clk, rst (sync, active-high); stage-2 request/tag status
//   (s2_valid, s2_write, s2_hit, s2_hit_way, s2_victim_dirty, s2_victim_way);
//   mem_resp from the memory arbiter. Outputs: stage_load, stall, cpu_resp,
//   mem_read, mem_write, addr_sel, data_we, tag_we, valid_set, dirty_set,
//   dirty_clr, way_sel. CACHE_PERF_CNT_EN adds hit_count and miss_count.
module pipeline_cache_ctrl #(
  parameter  int NUM_WAYS = 2,
  localparam int W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s2_valid,
  input  logic         s2_write,
  input  logic         s2_hit,
  input  logic [W-1:0] s2_hit_way,
  input  logic         s2_victim_dirty,
  input  logic [W-1:0] s2_victim_way,
  input  logic         mem_resp,
  output logic         stage_load,
  output logic         stall,
  output logic         cpu_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic         addr_sel,
  output logic         data_we,
  output logic         tag_we,
  output logic         valid_set,
  output logic         dirty_set,
  output logic         dirty_clr,
  output logic [W-1:0] way_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  typedef enum logic [2:0] {
    RUN, WB, FETCH, FILL, REPLAY
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] victim_q;
  logic         miss;

  assign miss = s2_valid & ~s2_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      // Victim choice is only valid with the missing request.
      if (state_q == RUN && miss)
        victim_q <= s2_victim_way;
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_load = 1'b0;
    stall      = 1'b0;
    cpu_resp   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    valid_set  = 1'b0;
    dirty_set  = 1'b0;
    dirty_clr  = 1'b0;
    way_sel    = '0;
    // Outputs forced low during reset so the arbiter sees no request.
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (miss) begin
            stall   = 1'b1;
            state_d = s2_victim_dirty ? WB : FETCH;
          end else begin
            stage_load = 1'b1;
            cpu_resp   = s2_valid;
            if (s2_valid && s2_write) begin
              data_we   = 1'b1;
              dirty_set = 1'b1;
              way_sel   = s2_hit_way;
            end
          end
        end
        WB: begin
          mem_write = 1'b1;
          addr_sel  = 1'b1;
          way_sel   = victim_q;
          stall     = 1'b1;
          if (mem_resp)
            state_d = FETCH;
        end
        FETCH: begin
          mem_read = 1'b1;
          addr_sel = 1'b1;
          way_sel  = victim_q;
          stall    = 1'b1;
          if (mem_resp)
            state_d = FILL;
        end
        FILL: begin
          data_we   = 1'b1;
          tag_we    = 1'b1;
          valid_set = 1'b1;
          dirty_clr = 1'b1;
          way_sel   = victim_q;
          stall     = 1'b1;
          state_d   = REPLAY;
        end
        REPLAY: begin
          // Reload the stalled request; it hits on the next RUN cycle.
          addr_sel   = 1'b1;
          stage_load = 1'b1;
          stall      = 1'b1;
          state_d    = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == RUN && cpu_resp && hit_count != '1)
        hit_count <= hit_count + 32'd1;
      if (state_q == RUN && miss && miss_count != '1)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_cache_ctrl.sv
// tb_pipeline_cache_ctrl: directed + random stimulus for pipeline_cache_ctrl.
// Reference model: a script queue of miss-handling steps per miss.
module tb_pipeline_cache_ctrl;

  localparam int W = 1;

  logic         clk;
  logic         rst;
  logic         s2_valid, s2_write, s2_hit;
  logic [W-1:0] s2_hit_way, s2_victim_way;
  logic         s2_victim_dirty, mem_resp;
  logic         stage_load, stall, cpu_resp;
  logic         mem_read, mem_write, addr_sel;
  logic         data_we, tag_we, valid_set;
  logic         dirty_set, dirty_clr;
  logic [W-1:0] way_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  hit_count, miss_count;
`endif

  pipeline_cache_ctrl #(.NUM_WAYS(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .s2_valid        (s2_valid),
    .s2_write        (s2_write),
    .s2_hit          (s2_hit),
    .s2_hit_way      (s2_hit_way),
    .s2_victim_dirty (s2_victim_dirty),
    .s2_victim_way   (s2_victim_way),
    .mem_resp        (mem_resp),
    .stage_load      (stage_load),
    .stall           (stall),
    .cpu_resp        (cpu_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .addr_sel        (addr_sel),
    .data_we         (data_we),
    .tag_we          (tag_we),
    .valid_set       (valid_set),
    .dirty_set       (dirty_set),
    .dirty_clr       (dirty_clr),
    .way_sel         (way_sel)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: pending miss steps; empty queue means normal streaming.
  localparam int S_WB = 0, S_FETCH = 1, S_FILL = 2, S_REPLAY = 3;
  int           plan[$];
  logic [W-1:0] m_victim = '0;
  longint       m_hits = 0, m_miss = 0;

  task automatic step(input logic v, input logic w, input logic h,
                      input logic [W-1:0] hw, input logic d,
                      input logic [W-1:0] vw, input logic r,
                      input logic rs);
    logic e_sl, e_st, e_cr, e_mr, e_mw, e_as;
    logic e_dwe, e_twe, e_vs, e_ds, e_dc;
    logic [W-1:0] e_way;
    logic way_chk;
    @(negedge clk);
    s2_valid = v; s2_write = w; s2_hit = h;
    s2_hit_way = hw; s2_victim_dirty = d;
    s2_victim_way = vw; mem_resp = r; rst = rs;
    #1;
    {e_sl, e_st, e_cr, e_mr, e_mw, e_as} = '0;
    {e_dwe, e_twe, e_vs, e_ds, e_dc} = '0;
    e_way = '0;
    way_chk = 1'b0;
    if (rs) begin
      way_chk = 1'b1;
    end else if (plan.size() == 0) begin
      if (v && !h) begin
        e_st = 1'b1;
      end else begin
        e_sl = 1'b1;
        e_cr = v;
        if (v && w) begin
          e_dwe = 1'b1; e_ds = 1'b1;
          e_way = hw; way_chk = 1'b1;
        end
      end
    end else begin
      e_st = 1'b1;
      case (plan[0])
        S_WB: begin
          e_mw = 1'b1; e_as = 1'b1;
          e_way = m_victim; way_chk = 1'b1;
        end
        S_FETCH: begin
          e_mr = 1'b1; e_as = 1'b1;
        end
        S_FILL: begin
          e_dwe = 1'b1; e_twe = 1'b1;
          e_vs = 1'b1; e_dc = 1'b1;
          e_way = m_victim; way_chk = 1'b1;
        end
        default: begin
          e_as = 1'b1; e_sl = 1'b1;
        end
      endcase
    end
    chk("stage_load", stage_load, e_sl);
    chk("stall", stall, e_st);
    chk("cpu_resp", cpu_resp, e_cr);
    chk("mem_read", mem_read, e_mr);
    chk("mem_write", mem_write, e_mw);
    chk("addr_sel", addr_sel, e_as);
    chk("data_we", data_we, e_dwe);
    chk("tag_we", tag_we, e_twe);
    chk("valid_set", valid_set, e_vs);
    chk("dirty_set", dirty_set, e_ds);
    chk("dirty_clr", dirty_clr, e_dc);
    if (way_chk)
      chk("way_sel", way_sel, e_way);
`ifdef CACHE_PERF_CNT_EN
    chk("hit_count", hit_count, m_hits[31:0]);
    chk("miss_count", miss_count, m_miss[31:0]);
`endif
    // Advance model to the next cycle.
    if (rs) begin
      plan.delete();
      m_victim = '0;
      m_hits = 0;
      m_miss = 0;
    end else if (plan.size() == 0) begin
      if (e_cr && m_hits < 64'hFFFF_FFFF) m_hits++;
      if (v && !h) begin
        if (m_miss < 64'hFFFF_FFFF) m_miss++;
        m_victim = vw;
        if (d) plan.push_back(S_WB);
        plan.push_back(S_FETCH);
        plan.push_back(S_FILL);
        plan.push_back(S_REPLAY);
      end
    end else if (plan[0] == S_WB || plan[0] == S_FETCH) begin
      if (r) void'(plan.pop_front());
    end else begin
      void'(plan.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1;
    {s2_valid, s2_write, s2_hit, s2_victim_dirty, mem_resp} = '0;
    s2_hit_way = '0;
    s2_victim_way = '0;
    // Reset: outputs held low even with a live miss on the inputs.
    step(1, 0, 0, 0, 1, 1, 1, 1);
    step(1, 1, 1, 1, 0, 0, 0, 1);
    // Read-hit stream.
    repeat (4) step(1, 0, 1, 0, 0, 0, 0, 0);
    // Store hit in way 1.
    step(1, 1, 1, 1, 0, 0, 0, 0);
    // Clean miss, victim 1, response on third fetch cycle.
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    // Dirty store miss, victim 0.
    step(1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    // Reset during fetch; late response must not fill.
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) != 0,
           $urandom_range(1) == 1,
           $urandom_range(2) != 0,
           W'($urandom_range(1)),
           $urandom_range(1) == 1,
           W'($urandom_range(1)),
           $urandom_range(2) == 0,
           $urandom_range(63) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
